// File: rtl/pwr_sw_pkg.sv
// Shared types and default timing for the power-switch sequencer.
// The delay counter is sized from the longest of the three delays.
package pwr_sw_pkg;

  typedef enum logic [2:0] {
    ON     = 3'd0,
    ISO    = 3'd1,
    SW_OFF = 3'd2,
    OFF    = 3'd3,
    SW_ON  = 3'd4,
    SETTLE = 3'd5
  } pwr_state_t;

  localparam int ISO_DLY_DEF    = 2;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int ACK_TMO_DEF    = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pwr_sw_ctrl_if.sv
// Handshake between the sequencer (slave) and the switch chain / power manager (master).
interface pwr_sw_ctrl_if;
  logic pwr_on_req;
  logic sw_ack;
  logic sw_ctrl_net;
  logic iso_en;
  logic pwr_ready;
  logic pwr_off;
  logic err_tmo;

  modport master (
    output pwr_on_req, sw_ack,
    input  sw_ctrl_net, iso_en, pwr_ready, pwr_off, err_tmo
  );

  modport slave (
    input  pwr_on_req, sw_ack,
    output sw_ctrl_net, iso_en, pwr_ready, pwr_off, err_tmo
  );
endinterface

// File: rtl/pwr_dly_cnt.sv
// Saturating down-counter with synchronous load; flags when it sits at zero.
module pwr_dly_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/pwr_sw_ctrl_chk.sv
// Isolation safety properties of the sequencer outputs.
module pwr_sw_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic sw_ctrl_net_i,
  input logic iso_en_i,
  input logic pwr_ready_i
);

  a_iso_when_open: assert property (@(posedge clk) disable iff (rst)
    !sw_ctrl_net_i |-> iso_en_i);

  a_ready_clean: assert property (@(posedge clk) disable iff (rst)
    pwr_ready_i |-> (sw_ctrl_net_i && !iso_en_i));

endmodule

// File: rtl/pwr_sw_ctrl.sv
// Header-switch sequencer for one gated domain: isolate -> open -> off,
// close -> settle -> un-isolate, with an ack wait bounded by a timeout.
module pwr_sw_ctrl
  import pwr_sw_pkg::*;
#(
  parameter int ISO_DLY    = ISO_DLY_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int ACK_TMO    = ACK_TMO_DEF,
  parameter int CNT_W      = $clog2(max3(ISO_DLY, SETTLE_CYC, ACK_TMO)) + 1
) (
  input logic          clk,
  input logic          rst,
  pwr_sw_ctrl_if.slave bus
);

  pwr_state_t       state_q, state_d;
  logic             err_q;
  logic             tmo_set_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
  logic             sw_s, iso_s, rdy_s, off_s;

  pwr_dly_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load_s),
    .load_val_i(cnt_val_s),
    .dec_i     (cnt_dec_s),
    .zero_o    (cnt_zero_s)
  );

  // Next state and counter control; ack always beats timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    cnt_dec_s  = 1'b0;
    tmo_set_s  = 1'b0;
    case (state_q)
      ON: begin
        if (!bus.pwr_on_req) begin
          state_d    = ISO;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(ISO_DLY - 1);
        end else begin
          state_d = ON;
        end
      end
      ISO: begin
        if (cnt_zero_s) begin
          state_d    = SW_OFF;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(ACK_TMO - 1);
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      SW_OFF: begin
        if (!bus.sw_ack) begin
          state_d = OFF;
        end else if (cnt_zero_s) begin
          state_d   = OFF;
          tmo_set_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      OFF: begin
        if (bus.pwr_on_req) begin
          state_d    = SW_ON;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(ACK_TMO - 1);
        end else begin
          state_d = OFF;
        end
      end
      SW_ON: begin
        if (bus.sw_ack || cnt_zero_s) begin
          state_d    = SETTLE;
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(SETTLE_CYC - 1);
          tmo_set_s  = !bus.sw_ack;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero_s) begin
          state_d = ON;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: state_d = ON;
    endcase
  end

  // State and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ON;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | tmo_set_s;
    end
  end

  // Outputs depend on state only; unknown encodings keep the clamp on.
  always_comb begin
    sw_s  = 1'b1;
    iso_s = 1'b1;
    rdy_s = 1'b0;
    off_s = 1'b0;
    case (state_q)
      ON:      begin iso_s = 1'b0; rdy_s = 1'b1; end
      ISO:     sw_s = 1'b1;
      SW_OFF:  sw_s = 1'b0;
      OFF:     begin sw_s = 1'b0; off_s = 1'b1; end
      SW_ON:   sw_s = 1'b1;
      SETTLE:  sw_s = 1'b1;
      default: sw_s = 1'b1;
    endcase
  end

  assign bus.sw_ctrl_net = sw_s;
  assign bus.iso_en      = iso_s;
  assign bus.pwr_ready   = rdy_s;
  assign bus.pwr_off     = off_s;
  assign bus.err_tmo     = err_q;

  pwr_sw_ctrl_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .sw_ctrl_net_i(sw_s),
    .iso_en_i     (iso_s),
    .pwr_ready_i  (rdy_s)
  );

endmodule

// File: tb/tb_pwr_sw_ctrl.sv
// Self-checking bench for pwr_sw_ctrl: phase/elapsed-time reference model,
// directed latency and timeout pins, then randomized request/ack traffic.
module tb_pwr_sw_ctrl;
  import pwr_sw_pkg::*;

  localparam int P_ON = 0, P_ISO = 1, P_SWOFF = 2, P_OFF = 3, P_SWON = 4, P_SETTLE = 5;

  logic clk;
  logic rst;
  pwr_sw_ctrl_if bus ();

  pwr_sw_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Ack source: 0 = follow sw_ctrl_net with a delay, 1 = fixed value, 2 = random.
  int         ack_mode = 0;
  int         ack_dly  = 1;
  logic       ack_val  = 1'b1;
  logic [7:0] hist     = 8'hFF;

  // Reference: current phase, cycles spent in it, sticky error.
  int ph   = P_ON;
  int t    = 0;
  bit merr = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bus.pwr_off === 1'b1;
      1:       return bus.pwr_ready === 1'b1;
      default: return bus.sw_ctrl_net === 1'b0;
    endcase
  endfunction

  // Counts edges until the condition is seen at +1; returns aligned at +2.
  task automatic wait_for(input int sel, input int budget, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (cond(sel)) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_%0d: condition not seen within %0d cycles", sel, budget);
    end
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Switch-chain emulation, updated after the DUT has settled on each edge.
  initial begin
    bus.sw_ack = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      hist = {hist[6:0], bus.sw_ctrl_net};
      case (ack_mode)
        0:       bus.sw_ack = hist[ack_dly-1];
        1:       bus.sw_ack = ack_val;
        default: bus.sw_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: phases advance on elapsed-time targets and ack matches.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = P_ON; t = 0; merr = 1'b0;
      end else begin
        case (ph)
          P_ON:  if (!bus.pwr_on_req) begin ph = P_ISO; t = 0; end
          P_ISO: begin
            t++;
            if (t == ISO_DLY_DEF) begin ph = P_SWOFF; t = 0; end
          end
          P_SWOFF: begin
            t++;
            if (bus.sw_ack == 1'b0) ph = P_OFF;
            else if (t == ACK_TMO_DEF) begin ph = P_OFF; merr = 1'b1; end
          end
          P_OFF: if (bus.pwr_on_req) begin ph = P_SWON; t = 0; end
          P_SWON: begin
            t++;
            if (bus.sw_ack == 1'b1) begin ph = P_SETTLE; t = 0; end
            else if (t == ACK_TMO_DEF) begin ph = P_SETTLE; t = 0; merr = 1'b1; end
          end
          default: begin
            t++;
            if (t == SETTLE_CYC_DEF) ph = P_ON;
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      check1("cmp_sw",  bus.sw_ctrl_net, (ph != P_OFF) && (ph != P_SWOFF));
      check1("cmp_iso", bus.iso_en,      ph != P_ON);
      check1("cmp_rdy", bus.pwr_ready,   ph == P_ON);
      check1("cmp_off", bus.pwr_off,     ph == P_OFF);
      check1("cmp_err", bus.err_tmo,     merr);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.pwr_on_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check1("rst_sw", bus.sw_ctrl_net, 1'b1);
    check1("rst_iso", bus.iso_en, 1'b0);
    rst = 1'b0;
    step(20);
    check1("idle_rdy", bus.pwr_ready, 1'b1);
    check1("idle_off", bus.pwr_off, 1'b0);
    check1("idle_err", bus.err_tmo, 1'b0);

    // Immediate ack: ON->OFF and OFF->ON latencies.
    bus.pwr_on_req = 1'b0;
    wait_for(0, 20, n);
    checkn("dn_lat_ack1", n, 4);
    bus.pwr_on_req = 1'b1;
    wait_for(1, 20, n);
    checkn("up_lat_ack1", n, 6);

    // Ack follows the switch 3 cycles late.
    ack_dly = 3;
    step(4);
    bus.pwr_on_req = 1'b0;
    step(1);
    check1("t2_iso_first", bus.iso_en, 1'b1);
    check1("t2_sw_still", bus.sw_ctrl_net, 1'b1);
    step(2);
    check1("t2_sw_open", bus.sw_ctrl_net, 1'b0);
    wait_for(0, 20, n);
    checkn("t2_swoff_len", n, 3);
    bus.pwr_on_req = 1'b1;
    wait_for(1, 30, n);
    checkn("t2_up_lat", n, 8);

    // Ack stuck high: SW_OFF times out after exactly ACK_TMO cycles.
    ack_mode = 1; ack_val = 1'b1;
    step(1);
    bus.pwr_on_req = 1'b0;
    wait_for(2, 10, n);
    checkn("t3_to_swoff", n, 3);
    wait_for(0, 100, n);
    checkn("t3_swoff_len", n, 64);
    check1("t3_err_set", bus.err_tmo, 1'b1);
    bus.pwr_on_req = 1'b1;
    wait_for(1, 20, n);
    ack_mode = 0; ack_dly = 2;
    bus.pwr_on_req = 1'b0;
    wait_for(0, 20, n);
    bus.pwr_on_req = 1'b1;
    wait_for(1, 30, n);
    check1("t3_err_sticky", bus.err_tmo, 1'b1);

    // Request glitch during ISO is ignored until OFF is reached.
    ack_dly = 1;
    step(2);
    bus.pwr_on_req = 1'b0;
    step(1);
    bus.pwr_on_req = 1'b1;
    wait_for(0, 20, n);
    checkn("t4_reach_off", n, 3);
    wait_for(1, 20, n);
    checkn("t4_back_on", n, 6);

    // Reset asserted in SW_OFF acts immediately.
    ack_mode = 1; ack_val = 1'b1;
    bus.pwr_on_req = 1'b0;
    wait_for(2, 10, n);
    step(5);
    rst = 1'b1;
    #1;
    check1("t5_sw", bus.sw_ctrl_net, 1'b1);
    check1("t5_iso", bus.iso_en, 1'b0);
    check1("t5_rdy", bus.pwr_ready, 1'b1);
    check1("t5_err_clr", bus.err_tmo, 1'b0);
    #1;
    step(2);
    rst = 1'b0;
    bus.pwr_on_req = 1'b1;
    step(3);

    // Ack arrives on the final timeout cycle: treated as ack.
    bus.pwr_on_req = 1'b0;
    wait_for(2, 10, n);
    step(63);
    ack_val = 1'b0;
    wait_for(0, 3, n);
    checkn("t6_last_cycle", n, 1);
    check1("t6_no_err", bus.err_tmo, 1'b0);

    // Randomized traffic against the model.
    ack_mode = 0; ack_dly = 1;
    bus.pwr_on_req = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.pwr_on_req = ~bus.pwr_on_req;
      if (i % 60 == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) begin ack_mode = 0; ack_dly = $urandom_range(1, 6); end
        else if (r < 8) begin ack_mode = 1; ack_val = 1'($urandom_range(0, 1)); end
        else ack_mode = 2;
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
